if_id_stage: RTL

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/risc_pkg.sv | 35 +++
 rtl/if_id_skid.sv | 74 +++++++
 rtl/if_id_stage.sv | 75 +++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared instruction-format definitions: field widths, bit positions and the
// packed field bundle handed from fetch/decode to the sign-extend stage.
package risc_pkg;

  localparam int INSTR_BITS = 32;
  localparam int OPCODE_W   = 6;
  localparam int REG_W      = 5;
  localparam int IMM_W      = 16;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int IMM_LSB    = 0;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [IMM_W-1:0]    imm16;
  } instr_fields_t;

  // rd and imm16 overlap in bits [15:11]; both views are carried unchanged.
  function automatic instr_fields_t split_instr(input logic [INSTR_BITS-1:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPCODE_LSB +: OPCODE_W];
    f.rs     = instr[RS_LSB     +: REG_W];
    f.rt     = instr[RT_LSB     +: REG_W];
    f.rd     = instr[RD_LSB     +: REG_W];
    f.imm16  = instr[IMM_LSB    +: IMM_W];
    return f;
  endfunction

endpackage

// File: rtl/if_id_skid.sv
// Two-entry valid/ready buffer (main drives the outputs, skid absorbs one beat
// of backpressure). in_ready_o depends only on reset and registered state.
module if_id_skid #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         accept, drain;

  assign in_ready_o  = rst_n & ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign accept      = in_valid_i & in_ready_o;
  assign drain       = main_valid_q & out_ready_i;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      if (drain) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || drain) begin
        main_data_d  = in_data_i;
        main_valid_d = 1'b1;
      end else begin
        skid_data_d  = in_data_i;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // NOTE: payload registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: buffers fetch beats, splits instruction fields.
// Optional backpressure counter enabled by macro IF_ID_STALL_CNT_EN.
module if_id_stage
  import risc_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rt,
  output logic [REG_W-1:0]   out_rd,
  output logic [IMM_W-1:0]   out_imm16,
  output logic [PC_W-1:0]    out_pc,
  output logic [15:0]        stall_cnt
);

  localparam int PAYLOAD_W = PC_W + INSTR_W;

  logic [PAYLOAD_W-1:0] out_data;
  logic [INSTR_W-1:0]   out_instr;
  instr_fields_t        fields;

  if_id_skid #(.W(PAYLOAD_W)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   ({in_pc, in_instr}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
  );

  assign out_pc     = out_data[PAYLOAD_W-1 -: PC_W];
  assign out_instr  = out_data[INSTR_W-1:0];
  assign fields     = split_instr(out_instr);
  assign out_opcode = fields.opcode;
  assign out_rs     = fields.rs;
  assign out_rt     = fields.rt;
  assign out_rd     = fields.rd;
  assign out_imm16  = fields.imm16;

`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Flush deliberately leaves the count alone; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= 16'h0000;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
